// File: rtl/multadd_seq_pkg.sv
// Shared types and constants for the multadd_seq job sequencer.
package multadd_seq_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_RES_W  = 17;
    localparam logic        ADD_MODE   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/multadd_seq_tagpipe.sv
// DEPTH-deep 1-bit shift register marking which datapath results carry a real beat.
module multadd_seq_tagpipe #(
    parameter int unsigned DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_shift_in,
    output logic o_tag,
    output logic o_empty
);

    logic [DEPTH-1:0] r_pipe;
    logic [DEPTH:0]   w_ext;

    assign w_ext = {r_pipe, i_shift_in};
    assign o_tag = w_ext[DEPTH];
    // Empty once the current output stage has shifted out, so the drain can end on the last add.
    assign o_empty = ~|w_ext[DEPTH-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= w_ext[DEPTH-1:0];
        end
    end

endmodule

// File: rtl/multadd_seq.sv
// Job sequencer feeding the ALT_MULTADD datapath and accumulating its results into a dot product.
module multadd_seq
    import multadd_seq_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned RES_W      = DEF_RES_W,
    parameter int unsigned ACC_W      = 24,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned MA_LATENCY = 2
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iSTART,
    input  logic [LEN_W-1:0]  iLEN,
    input  logic              iVALID,
    output logic              oREADY,
    input  logic [DATA_W-1:0] iA0,
    input  logic [DATA_W-1:0] iA1,
    input  logic [DATA_W-1:0] iB0,
    input  logic [DATA_W-1:0] iB1,
    output logic [DATA_W-1:0] oMA_A0,
    output logic [DATA_W-1:0] oMA_A1,
    output logic [DATA_W-1:0] oMA_B0,
    output logic [DATA_W-1:0] oMA_B1,
    output logic              oMA_SEL,
    input  logic [RES_W-1:0]  iMA_RESULT,
    output logic [ACC_W-1:0]  oACC,
    output logic              oOVF,
    output logic              oBUSY,
    output logic              oDONE
);

    localparam int unsigned CNT_W = LEN_W + 1;
    localparam int unsigned SUM_W = ACC_W + 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_start;
    logic               w_accept;
    logic               w_tag;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count_inc;
    logic [SUM_W-1:0]   w_sum;

    logic [LEN_W-1:0]   r_count;
    logic [LEN_W-1:0]   r_len;
    logic [DATA_W-1:0]  r_a0, r_a1, r_b0, r_b1;
    logic               r_sel;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;

    assign w_accept    = iVALID & r_ready;
    assign w_count_inc = CNT_W'(r_count) + CNT_W'(1);
    assign w_sum       = SUM_W'(r_acc) + SUM_W'(iMA_RESULT);

    multadd_seq_tagpipe #(
        .DEPTH (MA_LATENCY)
    ) u_tagpipe (
        .i_clk      (iCLK),
        .i_rst_n    (iRST_N),
        .i_shift_in (w_accept),
        .o_tag      (w_tag),
        .o_empty    (w_empty)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iSTART) begin
                    w_start     = 1'b1;
                    w_state_nxt = (iLEN == '0) ? ST_DONE : ST_FEED;
                end
            end
            ST_FEED: begin
                if (w_accept && (w_count_inc == CNT_W'(r_len))) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_empty) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state; ready is only ever high while beats remain.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_count <= '0;
            r_len   <= '0;
            r_a0    <= '0;
            r_a1    <= '0;
            r_b0    <= '0;
            r_b1    <= '0;
            r_sel   <= 1'b0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_sel   <= ADD_MODE;
            r_ready <= (w_state_nxt == ST_FEED);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (w_state_nxt == ST_DONE);
            if (w_accept) begin
                r_a0 <= iA0;
                r_a1 <= iA1;
                r_b0 <= iB0;
                r_b1 <= iB1;
            end
            if (w_start) begin
                r_count <= '0;
                r_len   <= iLEN;
                r_acc   <= '0;
                r_ovf   <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_count <= LEN_W'(w_count_inc);
                end
                if (w_tag) begin
                    r_acc <= w_sum[ACC_W-1:0];
                    r_ovf <= r_ovf | w_sum[ACC_W];
                end
            end
        end
    end

    assign oREADY  = r_ready;
    assign oMA_A0  = r_a0;
    assign oMA_A1  = r_a1;
    assign oMA_B0  = r_b0;
    assign oMA_B1  = r_b1;
    assign oMA_SEL = r_sel;
    assign oACC    = r_acc;
    assign oOVF    = r_ovf;
    assign oBUSY   = r_busy;
    assign oDONE   = r_done;

endmodule

// File: doc/multadd_seq.md
# multadd_seq

Job sequencer for the ALT_MULTADD dual multiply-add datapath.
- Takes a job of LEN operand beats (A0,A1,B0,B1 per beat) over a valid/ready stream.
- Drives each beat into ALT_MULTADD with add mode selected, and tracks the datapath pipeline latency.
- Accumulates every 17-bit multiply-add result into a wide accumulator and reports the dot product with a done pulse.
- Sits at the parent level beside ALT_MULTADD; the parent wires oMA_* and iMA_RESULT to it.

## Interface
- DATA_W, 8, operand width (matches ALT_MULTADD)
- RES_W, 17, ALT_MULTADD result width
- ACC_W, 24, accumulator width
- LEN_W, 8, job length counter width
- MA_LATENCY, 2, edges from operand register to valid iMA_RESULT (≥1)

- iCLK  in  1  single clock, rising edge
- iRST_N  in  1  asynchronous, active-low reset
- iSTART  in  1  job start, sampled only in IDLE
- iLEN  in  LEN_W  beats in job, sampled with iSTART
- iVALID  in  1  operand beat valid
- oREADY  out  1  beat accepted at edge when iVALID&oREADY
- iA0, iA1, iB0, iB1  in  DATA_W each  operand beat
- oMA_A0, oMA_A1, oMA_B0, oMA_B1  out  DATA_W each  registered operands to ALT_MULTADD
- oMA_SEL  out  1  ALT_MULTADD mode; 1 = add (A0*B0 + A1*B1)
- iMA_RESULT  in  RES_W  ALT_MULTADD result
- oACC  out  ACC_W  accumulated dot product
- oOVF  out  1  sticky: accumulator wrapped during current job
- oBUSY  out  1  high in any state except IDLE
- oDONE  out  1  one-cycle completion pulse

## Operation
- States:
  - IDLE: iSTART → FEED, or DONE if iLEN=0.
  - FEED: beat counter reaches iLEN → DRAIN.
  - DRAIN: tag pipe empty → DONE.
  - DONE: one cycle → IDLE.
- On accepted start: ACC←0, OVF←0, beat counter←0, stored length←iLEN.
- oREADY = (state==FEED) & (count<len); purely from state, no combinational path from iVALID.
- Accepted beat: oMA_* ← operands, and a 1 is pushed into the MA_LATENCY-deep tag pipe.
- Cycles with no accepted beat: oMA_* hold their value and a 0 is pushed into the tag pipe.
- Tag-pipe output high: ACC ← ACC + zero-extended iMA_RESULT, modulo 2^ACC_W. A carry out sets oOVF.
- Arithmetic is unsigned only. Maximum per-beat result is 130050, which fits in RES_W.
- oMA_SEL is held at 1 whenever out of reset.
- iSTART in any state other than IDLE is ignored. iLEN is ignored except when sampled with an accepted start.
- oACC and oOVF hold their value from DONE until the next accepted start.

## Timing
- Reset values: oMA_*=0, oMA_SEL=0, oACC=0, oOVF=0, oBUSY=0, oDONE=0, oREADY=0; state=IDLE and tag pipe cleared.
- Reset mid-job aborts the job immediately, with no oDONE.
- Operands registered at edge t produce an iMA_RESULT that is stable before edge t+MA_LATENCY. That result is added at edge t+MA_LATENCY.
- With start at edge 0 and iVALID held high:
  - beats are accepted at edges 1..LEN;
  - the last add happens at edge LEN+MA_LATENCY, which is also the edge entering DONE;
  - oDONE is high for the cycle after that edge.
- Example: LEN=4, MA_LATENCY=2 → oDONE high between edges 6 and 7.
- iLEN=0: the state is DONE in the cycle after the start edge, with oACC=0.
- Each bubble (iVALID low in FEED) delays oDONE by exactly one cycle.

## Structure
- Package multadd_seq_pkg holds:
  - the state enum (IDLE, FEED, DRAIN, DONE);
  - the DATA_W and RES_W defaults;
  - the ADD_MODE=1 constant for oMA_SEL.
- One sub-module: multadd_seq_tagpipe, a parameterised MA_LATENCY-deep 1-bit shift register with async clear and an empty flag. The empty flag is the OR-reduction inverted.
- ALT_MULTADD is not instantiated inside this block.

## Test plan
- All operands 2, LEN=4, iVALID always high → oACC=32, oOVF=0, oDONE high between edges 6 and 7 after the start edge.
- All operands 255, LEN=200 → the true sum of 26,010,000 wraps, giving oACC=9,232,784 and oOVF=1.
- Same as the first scenario but iVALID toggles every cycle starting low → oACC=32, with oDONE delayed by the number of bubbles (4).
- LEN=0 → oDONE in the cycle after the start edge, oACC=0, no oMA_* change.
- iSTART pulsed during FEED with iLEN=9 → ignored; the original job completes with its own length and sum.
- iRST_N low for one cycle mid-FEED → every output returns to its reset value immediately and no oDONE occurs. A new job of all 2s with LEN=2 then yields 16.
